// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute sequencer for a simple ALU.
// Each instruction is two bytes (opcode, address) read from an instruction
// memory with one cycle of read latency, then executed in five cycles:
// F_OP, F_ADDR, RD, EX, WB. No pipelining.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     level; leaves IDLE when sampled high
//   pc_out                    instruction memory read address
//   mem_data                  memory read data (valid one cycle after pc_out)
//   alu_instruct/alu_address  latched opcode and address bytes
//   rf_rd_addr1/2, rf_rd_data1/2  register file read port
//   alu_data1/2, alu_result   registered ALU operands, combinational result
//   rf_we, rf_wr_sel, rf_wr_data  register file write port (one-hot select)
//   busy, halted, illegal, instr_count  status
module alu_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] pc_out,
  input  logic [7:0] mem_data,
  output logic [7:0] alu_instruct,
  output logic [7:0] alu_address,
  output logic [2:0] rf_rd_addr1,
  output logic [2:0] rf_rd_addr2,
  input  logic [7:0] rf_rd_data1,
  input  logic [7:0] rf_rd_data2,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  input  logic [7:0] alu_result,
  output logic       rf_we,
  output logic [3:0] rf_wr_sel,
  output logic [7:0] rf_wr_data,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output logic [7:0] instr_count
);

  typedef enum logic [2:0] {IDLE, F_OP, F_ADDR, RD, EX, WB, HALT} state_t;

  state_t     state;
  logic [7:0] pc;
  logic [4:0] opc;
  logic       is_alu, is_nop, is_halt, is_ill;

  assign opc     = alu_instruct[4:0];
  assign is_alu  = ((opc >= 5'h01) && (opc <= 5'h0F)) || (opc == 5'h11) || (opc == 5'h12);
  assign is_nop  = (opc == 5'h00);
  assign is_halt = (opc == 5'h1F);
  assign is_ill  = !(is_alu || is_nop || is_halt);

  // Address byte is fetched one address after the opcode byte.
  assign pc_out      = (state == F_ADDR) ? pc + 8'd1 : pc;
  assign rf_rd_addr1 = alu_address[7:5];
  assign rf_rd_addr2 = alu_address[4:2];
  // ALU result is only valid once the operands are registered, i.e. in WB,
  // so the write data follows it combinationally while the write is enabled.
  assign rf_wr_data  = rf_we ? alu_result : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= PC_RESET;
      alu_instruct <= 8'h00;
      alu_address  <= 8'h00;
      alu_data1    <= 8'h00;
      alu_data2    <= 8'h00;
      rf_we        <= 1'b0;
      rf_wr_sel    <= 4'b0000;
      busy         <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      instr_count  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= F_OP;
            busy  <= 1'b1;
          end
        end
        F_OP:   state <= F_ADDR;
        F_ADDR: begin
          alu_instruct <= mem_data;
          state        <= RD;
        end
        RD: begin
          alu_address <= mem_data;
          state       <= EX;
        end
        EX: begin
          alu_data1 <= rf_rd_data1;
          alu_data2 <= rf_rd_data2;
          // Write strobe is registered here so it is high for WB only and
          // an asynchronous reset during WB drops it at once.
          if (is_alu) begin
            rf_we     <= 1'b1;
            rf_wr_sel <= 4'(4'b0001 << alu_address[1:0]);
          end
          state <= WB;
        end
        WB: begin
          rf_we     <= 1'b0;
          rf_wr_sel <= 4'b0000;
          if (is_halt) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            pc          <= pc + 8'd2;
            instr_count <= instr_count + 8'd1;
            if (is_ill) illegal <= 1'b1;
            state <= F_OP;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter PC_RESET, default 8'h00, the program counter value after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  level; starts fetching from IDLE.
REQ-005 SHALL have port pc_out  output  8  instruction memory read address.
REQ-006 SHALL have port mem_data  input  8  memory read data, valid one cycle after pc_out.
REQ-007 SHALL have ports alu_instruct, alu_address  output  8 each  latched opcode byte and address byte driven to the ALU.
REQ-008 SHALL have ports rf_rd_addr1, rf_rd_addr2  output  3 each  register file read addresses, equal to alu_address[7:5] and [4:2].
REQ-009 SHALL have ports rf_rd_data1, rf_rd_data2  input  8 each  combinational register file read data.
REQ-010 SHALL have ports alu_data1, alu_data2  output  8 each  registered operands to the ALU.
REQ-011 SHALL have port alu_result  input  8  combinational ALU result.
REQ-012 SHALL have ports rf_we  output  1, rf_wr_sel  output  4 (one-hot destination), rf_wr_data  output  8.
REQ-013 SHALL have ports busy  output  1, halted  output  1, illegal  output  1 (sticky), instr_count  output  8.

Function
REQ-014 SHALL use FSM states IDLE, F_OP, F_ADDR, RD, EX, WB, HALT.
REQ-015 IDLE: pc_out=pc; start=1 -> F_OP next cycle, else stay.
REQ-016 F_OP: drive pc_out=pc; -> F_ADDR.
REQ-017 F_ADDR: latch mem_data into alu_instruct; drive pc_out=pc+1 (8-bit wrap, 0xFF+1=0x00); -> RD.
REQ-018 RD: latch mem_data into alu_address; -> EX.
REQ-019 EX: latch rf_rd_data1/2 into alu_data1/2; -> WB.
REQ-020 WB: rf_we=1 for exactly this cycle for ALU opcodes, rf_wr_data=alu_result, rf_wr_sel one-hot from alu_address[1:0] (00->0001, 01->0010, 10->0100, 11->1000); pc<=pc+2 mod 256; instr_count<=instr_count+1 (wraps); -> F_OP.
REQ-021 Opcode field is alu_instruct[4:0]; ALU opcodes are 5'h01-5'h0F, 5'h11, 5'h12.
REQ-022 Opcode 5'h00 (NOP): full WB cycle with rf_we=0, counted.
REQ-023 Opcode 5'h1F (HALT): in WB rf_we=0, pc not advanced, count not incremented; -> HALT.
REQ-024 Any other opcode: treated as NOP and sets illegal=1 until reset.
REQ-025 Instruction latency SHALL be 5 cycles F_OP..WB; no pipelining.
REQ-026 HALT: halted=1; start ignored; only rst exits.
REQ-027 busy=1 in F_OP, F_ADDR, RD, EX, WB; 0 in IDLE and HALT.
REQ-028 start deasserted mid-instruction SHALL NOT abort the instruction or sequencing.
REQ-029 rf_we SHALL be 0 in every state except WB.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, pc=PC_RESET, alu_instruct=alu_address=alu_data1=alu_data2=8'h00, rf_we=0, rf_wr_sel=4'b0000, rf_wr_data=8'h00, busy=0, halted=0, illegal=0, instr_count=8'h00.
REQ-031 Reset asserted in any state, including WB, SHALL suppress the write in that cycle.
REQ-032 After release, no fetch until start=1 sampled in IDLE.

Verification
REQ-033 Memory[0..1]={8'h01,8'b001_010_01}, R1=5, R2=7, start pulse -> WB in cycle 5 after F_OP: rf_we=1, rf_wr_sel=0010, rf_wr_data=alu_result (12), pc=2, instr_count=1.
REQ-034 Memory[2..3]={8'h1F,8'h00} after REQ-033 -> halted=1, busy=0, pc=2, instr_count=1, no write; further start ignored.
REQ-035 Opcode 8'h13 -> no write, illegal=1, pc advances by 2, instr_count increments.
REQ-036 PC_RESET=8'hFE, instruction at FE/FF -> fetch addresses FE then FF, next pc=8'h00.
REQ-037 rst asserted during WB of an ALU op -> rf_we=0 that cycle, all outputs at REQ-030 values, IDLE.
REQ-038 Opcode 5'h00 in a loop of 256 instructions -> instr_count wraps to 8'h00, rf_we never asserted.
